// File: rtl/sha_pad_ctrl_if.sv
// rtl/sha_pad_ctrl_if.sv - message-word input and pktmux-side output bundle for sha_pad_ctrl
interface sha_pad_ctrl_if;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] pkt;
    logic [63:0] msg_len;
    logic        pad_pkt;
    logic        zero_pkt;
    logic        mgln_pkt;
    logic        blk_last;
    logic        msg_done;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, pkt, msg_len,
               pad_pkt, zero_pkt, mgln_pkt, blk_last, msg_done
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, pkt, msg_len,
               pad_pkt, zero_pkt, mgln_pkt, blk_last, msg_done
    );
endinterface

// File: rtl/sha_pad_ctrl.sv
// rtl/sha_pad_ctrl.sv - hash padding sequencer driving pktmux data and select lines
module sha_pad_ctrl #(
    parameter int WORDS_PER_BLK = 8,
    parameter int IDXW          = $clog2(WORDS_PER_BLK)
) (
    input  logic          clk,
    input  logic          rst,
    sha_pad_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_DATA, S_PAD, S_ZERO, S_LEN} state_t;

    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(WORDS_PER_BLK - 1);
    localparam logic [IDXW-1:0] IDX_PENULT = IDXW'(WORDS_PER_BLK - 2);

    state_t          state, state_nxt;
    logic [IDXW-1:0] idx, idx_nxt, idx_inc;
    logic [63:0]     bitcnt, bitcnt_nxt;
    logic            done_q, done_nxt;
    logic            xfer;
    logic            out_valid_c, in_ready_c, pad_c, zero_c, mgln_c;
    logic [63:0]     pkt_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_DATA;
            idx    <= '0;
            bitcnt <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            bitcnt <= bitcnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Explicit wrap keeps non-power-of-two block sizes correct.
    assign idx_inc = (idx == IDX_LAST) ? '0 : idx + IDXW'(1);

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        bitcnt_nxt  = bitcnt;
        done_nxt    = 1'b0;
        out_valid_c = 1'b0;
        in_ready_c  = 1'b0;
        pkt_c       = '0;
        pad_c       = 1'b0;
        zero_c      = 1'b0;
        mgln_c      = 1'b0;
        xfer        = 1'b0;

        if (!rst) begin
            unique case (state)
                S_DATA: begin
                    out_valid_c = bus.in_valid;
                    in_ready_c  = bus.out_ready;
                    pkt_c       = bus.in_data;
                end
                S_PAD: begin
                    out_valid_c = 1'b1;
                    pad_c       = 1'b1;
                end
                S_ZERO: begin
                    out_valid_c = 1'b1;
                    zero_c      = 1'b1;
                end
                S_LEN: begin
                    out_valid_c = 1'b1;
                    mgln_c      = 1'b1;
                end
            endcase
        end

        xfer = out_valid_c && bus.out_ready;

        if (xfer) begin
            idx_nxt = idx_inc;
            unique case (state)
                S_DATA: begin
                    bitcnt_nxt = bitcnt + 64'd64;
                    if (bus.in_last) state_nxt = S_PAD;
                end
                // A pad landing in the penultimate slot goes straight to the length word.
                S_PAD: state_nxt = (idx_inc == IDX_LAST) ? S_LEN : S_ZERO;
                S_ZERO: begin
                    if (idx == IDX_PENULT) state_nxt = S_LEN;
                end
                S_LEN: begin
                    state_nxt  = S_DATA;
                    idx_nxt    = '0;
                    bitcnt_nxt = '0;
                    done_nxt   = 1'b1;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.pkt       = pkt_c;
    assign bus.pad_pkt   = pad_c;
    assign bus.zero_pkt  = zero_c;
    assign bus.mgln_pkt  = mgln_c;
    assign bus.msg_len   = bitcnt;
    assign bus.blk_last  = (idx == IDX_LAST);
    assign bus.msg_done  = done_q && !rst;
endmodule

// File: tb/tb_sha_pad_ctrl.sv
// tb/tb_sha_pad_ctrl.sv - randomized self-checking bench for sha_pad_ctrl
module tb_sha_pad_ctrl;
    localparam int WPB    = 8;
    localparam int K_DATA = 0;
    localparam int K_PAD  = 1;
    localparam int K_ZERO = 2;
    localparam int K_LEN  = 3;

    typedef struct {
        int          kind;
        logic [63:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_pad_ctrl_if bus ();

    sha_pad_ctrl #(.WORDS_PER_BLK(WPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    item_t       exp_q[$];
    int          pos = 0;
    logic [63:0] cur_bits = '0;
    logic        done_pending = 1'b0;
    int          cur_xfers = 0;
    int          last_xfers = 0;
    int          done_cnt = 0;
    logic [63:0] last_len = '0;
    int          last_pad_pos = -1;
    int          ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Zero words needed so that data + pad + zeros + length fills whole blocks.
    function automatic int zeros_for(input int n);
        return (WPB - ((n + 2) % WPB)) % WPB;
    endfunction

    initial begin : ready_drv
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    initial begin : cmp
        logic        prev_stall;
        logic [63:0] prev_pkt;
        logic [2:0]  prev_sel;
        logic [2:0]  sel;
        logic [2:0]  esel;
        item_t       it;
        prev_stall = 1'b0;
        prev_pkt   = '0;
        prev_sel   = '0;
        forever begin
            @(negedge clk);
            sel = {bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt};
            if (rst) begin
                exp_q.delete();
                pos          = 0;
                cur_bits     = '0;
                done_pending = 1'b0;
                cur_xfers    = 0;
                prev_stall   = 1'b0;
            end else begin
                chk("msg_done", 64'(bus.msg_done), 64'(done_pending));
                chk("blk_last", 64'(bus.blk_last), 64'(pos == WPB - 1));
                chk("msg_len", bus.msg_len, cur_bits);
                chk("sel_onehot", 64'($countones(sel) <= 1), 64'd1);
                if (prev_stall) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("hold_pkt", bus.pkt, prev_pkt);
                    chk("hold_sel", 64'(sel), 64'(prev_sel));
                end
                if (exp_q.size() > 0 && exp_q[0].kind != K_DATA) begin
                    chk("fill_valid", 64'(bus.out_valid), 64'd1);
                    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
                end else begin
                    chk("data_valid", 64'(bus.out_valid), 64'(bus.in_valid));
                    chk("data_in_ready", 64'(bus.in_ready), 64'(bus.out_ready));
                end
                done_pending = 1'b0;
                if (bus.out_valid && bus.out_ready) begin
                    chk("model_has_word", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        it   = exp_q.pop_front();
                        esel = {it.kind == K_PAD, it.kind == K_ZERO, it.kind == K_LEN};
                        chk("pkt", bus.pkt, (it.kind == K_DATA) ? it.data : 64'd0);
                        chk("sel", 64'(sel), 64'(esel));
                        cur_xfers++;
                        if (it.kind == K_DATA) cur_bits = cur_bits + 64'd64;
                        if (it.kind == K_PAD) last_pad_pos = pos;
                        if (it.kind == K_LEN) begin
                            last_len     = bus.msg_len;
                            last_xfers   = cur_xfers;
                            cur_xfers    = 0;
                            cur_bits     = '0;
                            done_pending = 1'b1;
                            done_cnt++;
                        end
                    end
                    pos = (pos + 1) % WPB;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_pkt   = bus.pkt;
                prev_sel   = sel;
            end
        end
    end

    // Queues the full expected word sequence, then feeds the data words with optional gaps.
    task automatic send_msg(input int n, input int max_gap, input bit fix0, input logic [63:0] w0);
        logic [63:0] w[$];
        item_t       it;
        int          gap;
        int          budget;
        logic        acc;
        for (int i = 0; i < n; i++) w.push_back((i == 0 && fix0) ? w0 : {$urandom, $urandom});
        for (int i = 0; i < n; i++) begin
            it.kind = K_DATA; it.data = w[i]; exp_q.push_back(it);
        end
        it.kind = K_PAD; it.data = '0; exp_q.push_back(it);
        for (int i = 0; i < zeros_for(n); i++) begin
            it.kind = K_ZERO; exp_q.push_back(it);
        end
        it.kind = K_LEN; exp_q.push_back(it);
        for (int i = 0; i < n; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = {$urandom, $urandom};
                bus.in_last  = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            bus.in_last  = (i == n - 1);
            acc    = 1'b0;
            budget = 0;
            while (!acc && budget < 500) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: word %0d of %0d never accepted", i, n);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 0;
        while (done_cnt < target && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (done_cnt < target) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: done count %0d expected %0d", done_cnt, target);
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD_BEEF_0000_0001;
        bus.in_last  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_sel", 64'({bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt}), 64'd0);
        chk("rst_msg_done", 64'(bus.msg_done), 64'd0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_msg_len", bus.msg_len, 64'd0);
        chk("idle_blk_last", 64'(bus.blk_last), 64'd0);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        chk("zeros_for_1", 64'(zeros_for(1)), 64'd5);
        chk("zeros_for_7", 64'(zeros_for(7)), 64'd7);
        chk("zeros_for_8", 64'(zeros_for(8)), 64'd6);

        base = done_cnt;
        send_msg(1, 0, 1'b1, 64'h0123_4567_89AB_CDEF);
        wait_done(base + 1);
        chk("w1_len", last_len, 64'd64);
        chk("w1_xfers", 64'(last_xfers), 64'd8);

        base = done_cnt;
        send_msg(7, 0, 1'b0, '0);
        wait_done(base + 1);
        chk("w7_len", last_len, 64'd448);
        chk("w7_xfers", 64'(last_xfers), 64'd16);
        chk("w7_pad_pos", 64'(last_pad_pos), 64'd7);

        base = done_cnt;
        send_msg(8, 0, 1'b0, '0);
        wait_done(base + 1);
        chk("w8_len", last_len, 64'd512);
        chk("w8_xfers", 64'(last_xfers), 64'd16);
        chk("w8_pad_pos", 64'(last_pad_pos), 64'd0);

        base = done_cnt;
        send_msg(1, 0, 1'b0, '0);
        send_msg(1, 0, 1'b0, '0);
        wait_done(base + 2);
        chk("b2b_len", last_len, 64'd64);
        chk("b2b_xfers", 64'(last_xfers), 64'd8);

        ready_mode = 2;
        base = done_cnt;
        send_msg(3, 0, 1'b0, '0);
        wait_done(base + 1);
        ready_mode = 0;
        chk("tog_len", last_len, 64'd192);
        chk("tog_xfers", 64'(last_xfers), 64'd8);
        @(posedge clk);
        #1;

        send_msg(1, 0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_sel", 64'({bus.pad_pkt, bus.zero_pkt, bus.mgln_pkt}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_msg_len", bus.msg_len, 64'd0);
        chk("post_rst_blk_last", 64'(bus.blk_last), 64'd0);
        @(posedge clk);
        #1;
        base = done_cnt;
        send_msg(2, 0, 1'b0, '0);
        wait_done(base + 1);
        chk("rst2_len", last_len, 64'd128);
        chk("rst2_xfers", 64'(last_xfers), 64'd8);

        ready_mode = 1;
        base = done_cnt;
        for (int m = 0; m < 30; m++) send_msg(int'($urandom_range(1, 20)), 3, 1'b0, '0);
        wait_done(base + 30);
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
